// File: rtl/cpu_agu_pkg.sv
// Shared encodings for the address-generation front end: addressing modes and FSM states.
package cpu_agu_pkg;

   typedef enum logic [3:0] {
      MODE_IMP = 4'd0,
      MODE_IMM = 4'd1,
      MODE_ZP  = 4'd2,
      MODE_ZPX = 4'd3,
      MODE_ZPY = 4'd4,
      MODE_ABS = 4'd5,
      MODE_ABX = 4'd6,
      MODE_ABY = 4'd7,
      MODE_NDX = 4'd8,
      MODE_NDY = 4'd9,
      MODE_IND = 4'd10,
      MODE_REL = 4'd11
   } agu_mode_e;

   localparam logic [2:0] ST_FETCH_OP = 3'd0;
   localparam logic [2:0] ST_FETCH_LO = 3'd1;
   localparam logic [2:0] ST_FETCH_HI = 3'd2;
   localparam logic [2:0] ST_PTR_LO   = 3'd3;
   localparam logic [2:0] ST_PTR_HI   = 3'd4;
   localparam logic [2:0] ST_READ_OP  = 3'd5;
   localparam logic [2:0] ST_HOLD     = 3'd6;

endpackage

// File: rtl/cpu_agu_decode.sv
// Opcode classifier: addressing mode plus a flag for opcodes that never read their operand.
module cpu_agu_decode
   import cpu_agu_pkg::*;
(
   input  logic [7:0] opcode,
   output logic [3:0] mode,
   output logic       skip_read
);

   agu_mode_e m;

   // Ordered priority chain: the explicit opcodes must beat the bit-pattern rows below.
   always_comb begin
      m = MODE_IMP;
      if (opcode == 8'h6C)                              m = MODE_IND;
      else if (opcode == 8'h20)                         m = MODE_ABS;
      else if (opcode == 8'hB6 || opcode == 8'h96)      m = MODE_ZPY;
      else if (opcode[4:0] == 5'b00001)                 m = MODE_NDX;
      else if (opcode[4:0] == 5'b10001)                 m = MODE_NDY;
      else if (opcode[4:0] == 5'b01001 || (opcode[7] && opcode[4:0] == 5'b00000) ||
               opcode == 8'hA2)                         m = MODE_IMM;
      else if (opcode[4:0] == 5'b10000)                 m = MODE_REL;
      else if (opcode[4:0] == 5'b11001 || opcode == 8'hBE || opcode == 8'h9E)
                                                        m = MODE_ABY;
      else begin
         case (opcode[4:2])
            3'b001:  m = MODE_ZP;
            3'b011:  m = MODE_ABS;
            3'b101:  m = MODE_ZPX;
            3'b111:  m = MODE_ABX;
            default: m = MODE_IMP;
         endcase
      end
   end

   assign mode      = m;
   assign skip_read = (opcode == 8'h4C) || (opcode == 8'h20) || (opcode[7:5] == 3'b100);

endmodule

// File: rtl/cpu_agu.sv
// 6502-style fetch/address-generation unit: walks instruction bytes, resolves the effective
// address and operand, and holds one decoded instruction until the execute stage takes it.
module cpu_agu
   import cpu_agu_pkg::*;
#(
   parameter logic [15:0] RESET_PC     = 16'h0000,
   parameter bit          IND_PAGE_BUG = 1'b1
) (
   input  logic        clock_25,
   input  logic        reset_n,
   output logic [15:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   input  logic [7:0]  idx_x,
   input  logic [7:0]  idx_y,
   input  logic        pc_load,
   input  logic [15:0] pc_new,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [7:0]  dec_opcode,
   output logic [3:0]  dec_mode,
   output logic [15:0] dec_ea,
   output logic [7:0]  dec_operand,
   output logic        dec_page_cross,
   output logic [15:0] dec_next_pc
);

   logic [2:0]  state_q;
   logic [15:0] pc_q, ptr_q, ea_q;
   logic [7:0]  opcode_q, lo_q, operand_q;
   logic [3:0]  mode_q;
   logic        skip_q, pcx_q;

   logic [3:0]  dmode;
   logic        dskip;

   cpu_agu_decode u_decode (
      .opcode    (mem_rdata),
      .mode      (dmode),
      .skip_read (dskip)
   );

   logic [7:0]  idx;
   logic [8:0]  lo_sum;
   logic [15:0] ea_idx, pc_inc, rel_ea, ptr_hi_addr;
   logic [2:0]  rd_state;

   assign idx      = (mode_q == MODE_ZPY || mode_q == MODE_ABY || mode_q == MODE_NDY) ? idx_y : idx_x;
   // lo_q holds the base low byte for both ABX/ABY (in FETCH_HI) and NDY (in PTR_HI).
   assign lo_sum   = {1'b0, lo_q} + {1'b0, idx};
   assign ea_idx   = {mem_rdata + {7'b0, lo_sum[8]}, lo_sum[7:0]};
   assign pc_inc   = pc_q + 16'd1;
   assign rel_ea   = pc_inc + {{8{mem_rdata[7]}}, mem_rdata};
   assign rd_state = skip_q ? ST_HOLD : ST_READ_OP;

   always_comb begin
      if (mode_q == MODE_IND)
         ptr_hi_addr = IND_PAGE_BUG ? {ptr_q[15:8], ptr_q[7:0] + 8'd1} : ptr_q + 16'd1;
      else
         ptr_hi_addr = {8'h00, ptr_q[7:0] + 8'd1};
   end

   always_comb begin
      case (state_q)
         ST_PTR_LO:  mem_addr = ptr_q;
         ST_PTR_HI:  mem_addr = ptr_hi_addr;
         ST_READ_OP: mem_addr = ea_q;
         default:    mem_addr = pc_q;
      endcase
   end

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_FETCH_OP;
         pc_q      <= RESET_PC;
         opcode_q  <= 8'h00;
         mode_q    <= 4'h0;
         skip_q    <= 1'b0;
         lo_q      <= 8'h00;
         ptr_q     <= 16'h0000;
         ea_q      <= 16'h0000;
         operand_q <= 8'h00;
         pcx_q     <= 1'b0;
      end else if (pc_load) begin
         state_q <= ST_FETCH_OP;
         pc_q    <= pc_new;
      end else begin
         case (state_q)
            ST_FETCH_OP: if (mem_ready) begin
               pc_q      <= pc_inc;
               opcode_q  <= mem_rdata;
               mode_q    <= dmode;
               skip_q    <= dskip;
               ea_q      <= 16'h0000;
               operand_q <= 8'h00;
               pcx_q     <= 1'b0;
               state_q   <= (dmode == MODE_IMP) ? ST_HOLD : ST_FETCH_LO;
            end
            ST_FETCH_LO: if (mem_ready) begin
               pc_q <= pc_inc;
               lo_q <= mem_rdata;
               case (mode_q)
                  MODE_IMM: begin
                     ea_q <= pc_q;
                     if (!skip_q) operand_q <= mem_rdata;
                     state_q <= ST_HOLD;
                  end
                  MODE_REL: begin
                     ea_q  <= rel_ea;
                     pcx_q <= rel_ea[15:8] != pc_inc[15:8];
                     if (!skip_q) operand_q <= mem_rdata;
                     state_q <= ST_HOLD;
                  end
                  MODE_ZP: begin
                     ea_q    <= {8'h00, mem_rdata};
                     state_q <= rd_state;
                  end
                  MODE_ZPX, MODE_ZPY: begin
                     ea_q    <= {8'h00, mem_rdata + idx};
                     state_q <= rd_state;
                  end
                  MODE_NDX: begin
                     ptr_q   <= {8'h00, mem_rdata + idx_x};
                     state_q <= ST_PTR_LO;
                  end
                  MODE_NDY: begin
                     ptr_q   <= {8'h00, mem_rdata};
                     state_q <= ST_PTR_LO;
                  end
                  default: state_q <= ST_FETCH_HI;
               endcase
            end
            ST_FETCH_HI: if (mem_ready) begin
               pc_q <= pc_inc;
               if (mode_q == MODE_IND) begin
                  ptr_q   <= {mem_rdata, lo_q};
                  state_q <= ST_PTR_LO;
               end else begin
                  if (mode_q == MODE_ABS) begin
                     ea_q <= {mem_rdata, lo_q};
                  end else begin
                     ea_q  <= ea_idx;
                     pcx_q <= lo_sum[8];
                  end
                  state_q <= rd_state;
               end
            end
            ST_PTR_LO: if (mem_ready) begin
               lo_q    <= mem_rdata;
               state_q <= ST_PTR_HI;
            end
            ST_PTR_HI: if (mem_ready) begin
               if (mode_q == MODE_NDY) begin
                  ea_q  <= ea_idx;
                  pcx_q <= lo_sum[8];
               end else begin
                  ea_q <= {mem_rdata, lo_q};
               end
               state_q <= (mode_q == MODE_IND) ? ST_HOLD : rd_state;
            end
            ST_READ_OP: if (mem_ready) begin
               operand_q <= mem_rdata;
               state_q   <= ST_HOLD;
            end
            ST_HOLD: if (dec_ready) state_q <= ST_FETCH_OP;
            default: state_q <= ST_FETCH_OP;
         endcase
      end
   end

   assign dec_valid      = (state_q == ST_HOLD);
   assign dec_opcode     = opcode_q;
   assign dec_mode       = mode_q;
   assign dec_ea         = ea_q;
   assign dec_operand    = operand_q;
   assign dec_page_cross = pcx_q;
   // PC only stops moving once the last byte is fetched, so expose it only while holding.
   assign dec_next_pc    = dec_valid ? pc_q : 16'h0000;

endmodule

// File: tb/tb_cpu_agu.sv
// Directed bench for cpu_agu: a flat memory model, expected decode records queued at issue
// and compared when the unit presents its result. A second instance runs with IND_PAGE_BUG=0.
module tb_cpu_agu;
   import cpu_agu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] mem_addr, mem_addr2;
   logic [7:0]  mem_rdata, mem_rdata2;
   logic        mem_ready = 1'b1;
   logic [7:0]  idx_x = 8'h00, idx_y = 8'h00;
   logic        pc_load = 1'b0;
   logic [15:0] pc_new = 16'h0000;
   logic        dec_valid, dec_valid2;
   logic        dec_ready = 1'b0;
   logic [7:0]  dec_opcode, dec_opcode2, dec_operand, dec_operand2;
   logic [3:0]  dec_mode, dec_mode2;
   logic [15:0] dec_ea, dec_ea2, dec_next_pc, dec_next_pc2;
   logic        dec_page_cross, dec_page_cross2;

   logic [7:0] mem [0:65535];
   assign mem_rdata  = mem[mem_addr];
   assign mem_rdata2 = mem[mem_addr2];

   always #20 clk = ~clk;

   cpu_agu #(.RESET_PC(16'h0000), .IND_PAGE_BUG(1'b1)) dut (
      .clock_25(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .idx_x(idx_x), .idx_y(idx_y), .pc_load(pc_load), .pc_new(pc_new),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode), .dec_mode(dec_mode),
      .dec_ea(dec_ea), .dec_operand(dec_operand), .dec_page_cross(dec_page_cross),
      .dec_next_pc(dec_next_pc));

   cpu_agu #(.RESET_PC(16'h0000), .IND_PAGE_BUG(1'b0)) dut2 (
      .clock_25(clk), .reset_n(reset_n), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
      .mem_ready(mem_ready), .idx_x(idx_x), .idx_y(idx_y), .pc_load(pc_load), .pc_new(pc_new),
      .dec_valid(dec_valid2), .dec_ready(dec_ready), .dec_opcode(dec_opcode2), .dec_mode(dec_mode2),
      .dec_ea(dec_ea2), .dec_operand(dec_operand2), .dec_page_cross(dec_page_cross2),
      .dec_next_pc(dec_next_pc2));

   typedef struct {
      logic [7:0]  opc;
      logic [3:0]  mode;
      logic [15:0] ea;
      logic [15:0] ea2;
      logic [7:0]  opr;
      logic        pcx;
      logic [15:0] npc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] opc, input logic [3:0] mode, input logic [15:0] ea,
                               input logic [15:0] ea2, input logic [7:0] opr, input logic pcx,
                               input logic [15:0] npc, input int lat);
      exp_t e;
      e.opc = opc; e.mode = mode; e.ea = ea; e.ea2 = ea2;
      e.opr = opr; e.pcx = pcx; e.npc = npc; e.lat = lat;
      return e;
   endfunction

   task automatic start_at(input logic [15:0] a);
      @(posedge clk); #1 pc_load = 1'b1; pc_new = a;
      @(posedge clk); #1 pc_load = 1'b0;
   endtask

   // Called #1 into the FETCH_OP cycle; counts rising edges until dec_valid.
   task automatic wait_and_check(input int stall);
      exp_t e;
      int n;
      n = 0;
      @(negedge clk);
      while (!dec_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("valid_timeout", 32'(dec_valid), 32'(1));
      e = sb.pop_front();
      if (e.lat >= 0) chk("latency", 32'(n), 32'(e.lat));
      chk("opcode",     32'(dec_opcode),     32'(e.opc));
      chk("mode",       32'(dec_mode),       32'(e.mode));
      chk("ea",         32'(dec_ea),         32'(e.ea));
      chk("ea_nobug",   32'(dec_ea2),        32'(e.ea2));
      chk("operand",    32'(dec_operand),    32'(e.opr));
      chk("page_cross", 32'(dec_page_cross), 32'(e.pcx));
      chk("next_pc",    32'(dec_next_pc),    32'(e.npc));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_valid",   32'(dec_valid),   32'(1));
         chk("stall_ea",      32'(dec_ea),      32'(e.ea));
         chk("stall_operand", 32'(dec_operand), 32'(e.opr));
         chk("stall_next_pc", 32'(dec_next_pc), 32'(e.npc));
      end
      dec_ready = 1'b1;
      @(posedge clk); #1 dec_ready = 1'b0;
      chk("post_accept_valid", 32'(dec_valid), 32'(0));
      chk("post_accept_addr",  32'(mem_addr),  32'(e.npc));
   endtask

   task automatic run(input logic [15:0] a, input exp_t e, input int stall);
      sb.push_back(e);
      start_at(a);
      wait_and_check(stall);
   endtask

   initial begin
      logic [15:0] held;
      logic        was_low;

      for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
      mem[16'h0000] = 8'hA5; mem[16'h0001] = 8'h10; mem[16'h0010] = 8'h77;
      mem[16'h0100] = 8'hB5; mem[16'h0101] = 8'h80; mem[16'h007F] = 8'h5A;
      mem[16'h0400] = 8'hB1; mem[16'h0401] = 8'h40;
      mem[16'h0040] = 8'hF8; mem[16'h0041] = 8'h12; mem[16'h1308] = 8'h99;
      mem[16'h0500] = 8'h6C; mem[16'h0501] = 8'hFF; mem[16'h0502] = 8'h02;
      mem[16'h02FF] = 8'h34; mem[16'h0200] = 8'h12; mem[16'h0300] = 8'h56;
      mem[16'h0600] = 8'hA1; mem[16'h0601] = 8'h20;
      mem[16'h0024] = 8'hCD; mem[16'h0025] = 8'hAB; mem[16'hABCD] = 8'hEE;
      mem[16'h0700] = 8'hBD; mem[16'h0701] = 8'hF0; mem[16'h0702] = 8'h12; mem[16'h1310] = 8'h3C;
      mem[16'h0800] = 8'hB9; mem[16'h0801] = 8'hFF; mem[16'h0802] = 8'hFF;
      mem[16'h0900] = 8'hA9; mem[16'h0901] = 8'h42;
      mem[16'h0A00] = 8'hD0; mem[16'h0A01] = 8'hF0;
      mem[16'h0C00] = 8'h8D; mem[16'h0C01] = 8'h34; mem[16'h0C02] = 8'h12;
      mem[16'h0D00] = 8'h4C; mem[16'h0D01] = 8'h00; mem[16'h0D02] = 8'h20;
      mem[16'h0E00] = 8'hB6; mem[16'h0E01] = 8'hF0;
      mem[16'h0F00] = 8'hAD; mem[16'h0F01] = 8'h10; mem[16'h0F02] = 8'h00;
      mem[16'hFFFF] = 8'hA9;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_addr",     32'(mem_addr),       32'h0000);
      chk("rst_valid",    32'(dec_valid),      32'(0));
      chk("rst_opcode",   32'(dec_opcode),     32'(0));
      chk("rst_mode",     32'(dec_mode),       32'(0));
      chk("rst_ea",       32'(dec_ea),         32'(0));
      chk("rst_operand",  32'(dec_operand),    32'(0));
      chk("rst_pcx",      32'(dec_page_cross), 32'(0));
      chk("rst_next_pc",  32'(dec_next_pc),    32'(0));
      @(posedge clk); #1 reset_n = 1'b1;

      // ZP straight out of reset
      sb.push_back(mk(8'hA5, MODE_ZP, 16'h0010, 16'h0010, 8'h77, 1'b0, 16'h0002, 3));
      wait_and_check(0);

      idx_x = 8'hFF;
      run(16'h0100, mk(8'hB5, MODE_ZPX, 16'h007F, 16'h007F, 8'h5A, 1'b0, 16'h0102, 3), 0);

      idx_y = 8'h10;
      run(16'h0400, mk(8'hB1, MODE_NDY, 16'h1308, 16'h1308, 8'h99, 1'b1, 16'h0402, 5), 5);

      run(16'h0500, mk(8'h6C, MODE_IND, 16'h1234, 16'h5634, 8'h00, 1'b0, 16'h0503, 5), 0);

      idx_x = 8'h04;
      run(16'h0600, mk(8'hA1, MODE_NDX, 16'hABCD, 16'hABCD, 8'hEE, 1'b0, 16'h0602, 5), 0);

      idx_x = 8'h20;
      run(16'h0700, mk(8'hBD, MODE_ABX, 16'h1310, 16'h1310, 8'h3C, 1'b1, 16'h0703, 4), 0);

      idx_y = 8'h02;
      run(16'h0800, mk(8'hB9, MODE_ABY, 16'h0001, 16'h0001, 8'h10, 1'b1, 16'h0803, 4), 0);

      run(16'h0900, mk(8'hA9, MODE_IMM, 16'h0901, 16'h0901, 8'h42, 1'b0, 16'h0902, 2), 0);
      run(16'h0A00, mk(8'hD0, MODE_REL, 16'h09F2, 16'h09F2, 8'hF0, 1'b1, 16'h0A02, 2), 0);
      run(16'h0B00, mk(8'hEA, MODE_IMP, 16'h0000, 16'h0000, 8'h00, 1'b0, 16'h0B01, 1), 0);
      run(16'h0C00, mk(8'h8D, MODE_ABS, 16'h1234, 16'h1234, 8'h00, 1'b0, 16'h0C03, 3), 0);
      run(16'h0D00, mk(8'h4C, MODE_ABS, 16'h2000, 16'h2000, 8'h00, 1'b0, 16'h0D03, 3), 0);

      idx_y = 8'h20;
      run(16'h0E00, mk(8'hB6, MODE_ZPY, 16'h0010, 16'h0010, 8'h77, 1'b0, 16'h0E02, 3), 0);

      // PC wraps from FFFF to 0000 mid-instruction
      run(16'hFFFF, mk(8'hA9, MODE_IMM, 16'h0000, 16'h0000, 8'hA5, 1'b0, 16'h0001, 2), 0);

      // ABS with alternating wait states: address must not move during a wait cycle
      sb.push_back(mk(8'hAD, MODE_ABS, 16'h0010, 16'h0010, 8'h77, 1'b0, 16'h0F03, -1));
      start_at(16'h0F00);
      mem_ready = 1'b0;
      was_low = 1'b0;
      held = 16'h0000;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (was_low) chk("wait_addr_hold", 32'(mem_addr), 32'(held));
         if (dec_valid) break;
         was_low = !mem_ready;
         held = mem_addr;
         @(posedge clk); #1 mem_ready = !mem_ready;
      end
      mem_ready = 1'b1;
      wait_and_check(0);

      // Redirect during PTR_LO of an NDX instruction
      idx_x = 8'h04;
      start_at(16'h0600);
      @(posedge clk);
      @(posedge clk); #1 pc_load = 1'b1; pc_new = 16'hC000;
      @(posedge clk); #1 pc_load = 1'b0;
      chk("abort_addr",  32'(mem_addr),  32'hC000);
      chk("abort_valid", 32'(dec_valid), 32'(0));
      sb.push_back(mk(8'hEA, MODE_IMP, 16'h0000, 16'h0000, 8'h00, 1'b0, 16'hC001, 1));
      wait_and_check(0);

      // Reset in the middle of an ABS fetch
      start_at(16'h0F00);
      @(posedge clk); #2 reset_n = 1'b0;
      #1;
      chk("midrst_addr",   32'(mem_addr),   32'h0000);
      chk("midrst_valid",  32'(dec_valid),  32'(0));
      chk("midrst_opcode", 32'(dec_opcode), 32'(0));
      @(posedge clk); #1 reset_n = 1'b1;
      sb.push_back(mk(8'hA5, MODE_ZP, 16'h0010, 16'h0010, 8'h77, 1'b0, 16'h0002, 3));
      wait_and_check(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
